// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: round-robin arbiter that shares one ALU among N requesters.
// A granted request is latched, held stable on the ALU pins for its latency,
// then the captured result and flags are returned with the requester id.
module alu_req_arbiter #(
   parameter int WIDTH   = 8,
   parameter int N       = 4,
   parameter int IDW     = $clog2(N),
   parameter int LAT     = 1,
   parameter int MUL_LAT = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N-1:0]       req_valid,
   output logic [N-1:0]       req_ready,
   input  logic [N*WIDTH-1:0] req_opa,
   input  logic [N*WIDTH-1:0] req_opb,
   input  logic [N*4-1:0]     req_cmd,
   input  logic [N-1:0]       req_mode,
   input  logic [N-1:0]       req_cin,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [IDW-1:0]     rsp_id,
   output logic [WIDTH-1:0]   rsp_res,
   output logic [5:0]         rsp_flags,
   output logic [WIDTH-1:0]   alu_opa,
   output logic [WIDTH-1:0]   alu_opb,
   output logic [3:0]         alu_cmd,
   output logic               alu_mode,
   output logic               alu_cin,
   output logic               alu_ce,
   output logic [1:0]         alu_inp_valid,
   input  logic [WIDTH-1:0]   alu_res,
   input  logic               alu_oflow,
   input  logic               alu_cout,
   input  logic               alu_g,
   input  logic               alu_l,
   input  logic               alu_e,
   input  logic               alu_err,
   output logic               busy
);

   localparam int LMAX = (LAT > MUL_LAT) ? LAT : MUL_LAT;
   localparam int CW   = $clog2(LMAX + 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t           r_state, w_state_next;
   logic [IDW-1:0]   r_last;
   logic [IDW-1:0]   r_id;
   logic [WIDTH-1:0] r_opa, r_opb, r_res;
   logic [3:0]       r_cmd;
   logic             r_mode, r_cin;
   logic [CW-1:0]    r_cnt;
   logic [5:0]       r_flags;

   logic             w_found;
   logic [IDW-1:0]   w_sel;
   logic [N-1:0]     w_ready;
   logic             w_xfer;
   logic             w_active;
   logic [3:0]       w_sel_cmd;
   logic             w_sel_mode;
   logic             w_is_mul;

   // Round-robin search starting one past the last granted requester
   always_comb begin
      int idx;
      w_found = 1'b0;
      w_sel   = '0;
      idx     = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(r_last) + 1 + k) % N;
         if (!w_found && req_valid[idx]) begin
            w_found = 1'b1;
            w_sel   = IDW'(idx);
         end
      end
   end

   // Grant exactly the selected requester, only while idle and out of reset
   always_comb begin
      w_ready = '0;
      if (r_state == S_IDLE && !reset && w_found)
         w_ready[w_sel] = 1'b1;
   end

   assign req_ready  = w_ready;
   assign w_xfer     = |(req_valid & w_ready);
   assign w_sel_cmd  = req_cmd[w_sel*4 +: 4];
   assign w_sel_mode = req_mode[w_sel];
   assign w_is_mul   = w_sel_mode && (w_sel_cmd == 4'd9 || w_sel_cmd == 4'd10);

   // Next-state sequencing through issue, wait and response
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (w_xfer) w_state_next = S_ISSUE;
         S_ISSUE: w_state_next = S_WAIT;
         S_WAIT:  if (r_cnt == CW'(1)) w_state_next = S_RESP;
         S_RESP:  if (rsp_ready) w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   // Request latch, latency counter and result capture
   always_ff @(posedge clk) begin
      if (reset) begin
         r_last  <= IDW'(N - 1);
         r_id    <= '0;
         r_opa   <= '0;
         r_opb   <= '0;
         r_cmd   <= '0;
         r_mode  <= 1'b0;
         r_cin   <= 1'b0;
         r_cnt   <= '0;
         r_res   <= '0;
         r_flags <= '0;
      end else begin
         if (w_xfer) begin
            r_last <= w_sel;
            r_id   <= w_sel;
            r_opa  <= req_opa[w_sel*WIDTH +: WIDTH];
            r_opb  <= req_opb[w_sel*WIDTH +: WIDTH];
            r_cmd  <= w_sel_cmd;
            r_mode <= w_sel_mode;
            r_cin  <= req_cin[w_sel];
            r_cnt  <= w_is_mul ? CW'(MUL_LAT) : CW'(LAT);
         end
         if (r_state == S_WAIT) begin
            if (r_cnt == CW'(1)) begin
               r_res   <= alu_res;
               r_flags <= {alu_err, alu_e, alu_l, alu_g, alu_cout, alu_oflow};
            end else begin
               r_cnt <= r_cnt - CW'(1);
            end
         end
      end
   end

   // ALU pins follow the latched request; enables only while the op is in flight
   assign w_active      = (r_state == S_ISSUE) || (r_state == S_WAIT);
   assign alu_ce        = w_active;
   assign alu_inp_valid = {2{w_active}};
   assign alu_opa       = r_opa;
   assign alu_opb       = r_opb;
   assign alu_cmd       = r_cmd;
   assign alu_mode      = r_mode;
   assign alu_cin       = r_cin;

   assign rsp_valid = (r_state == S_RESP);
   assign rsp_id    = r_id;
   assign rsp_res   = r_res;
   assign rsp_flags = r_flags;
   assign busy      = (r_state != S_IDLE);

endmodule

// File: doc/alu_req_arbiter.md
# alu_req_arbiter

Round-robin arbiter and sequencer that shares one ALU instance among N requesters. Each requester presents an operation over a valid/ready handshake. The block grants one requester at a time, drives the ALU input ports with stable operands for the operation's latency, captures result and flags, and returns them with the requester id over a valid/ready response channel. It sits between the ALU clients and the ALU, owning all ALU input pins.

## Interface

- WIDTH, 8, operand/result width
- N, 4, number of requesters (2..8)
- IDW, $clog2(N), requester id width
- LAT, 1, cycles from ALU sampling edge to valid result for ordinary commands (≥1)
- MUL_LAT, 2, same for multiply commands, i.e. mode=1 and cmd 9 or 10 (≥1)

Ports:

- clk  in  1  clock, all logic on posedge
- reset  in  1  synchronous, active-high
- req_valid  in  N  per-requester request valid
- req_ready  out  N  per-requester grant/accept; at most one bit set
- req_opa, req_opb  in  N*WIDTH each  packed operands, requester i at [i*WIDTH +: WIDTH]
- req_cmd  in  N*4  packed command
- req_mode, req_cin  in  N each  mode / carry-in
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  IDW  requester that owns the response
- rsp_res  out  WIDTH  captured ALU result
- rsp_flags  out  6  {err, e, l, g, cout, oflow} captured from ALU
- alu_opa, alu_opb  out  WIDTH  to ALU
- alu_cmd  out  4; alu_mode, alu_cin, alu_ce  out  1; alu_inp_valid  out  2
- alu_res  in  WIDTH; alu_oflow, alu_cout, alu_g, alu_l, alu_e, alu_err  in  1  from ALU
- busy  out  1  high in any state other than IDLE

## Operation

- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: combinationally selects the first requester with req_valid set, searching from (last_grant+1) mod N upward with wrap. The selected requester's req_ready is high in this cycle and all others are low. A transfer happens when req_valid[i] && req_ready[i]. On transfer:
  - opa, opb, cmd, mode, cin and id are registered.
  - last_grant <= i.
  - The wait count is loaded with MUL_LAT if mode=1 and cmd∈{9,10}, else LAT.
  - Next state is ISSUE.
- ISSUE: one cycle. Next state is WAIT.
- WAIT: the counter decrements each cycle. When it reaches 1, ALU outputs are sampled into rsp_res and rsp_flags at that edge and the next state is RESP.
- ALU pin values:
  - During ISSUE and WAIT: alu_ce=1, alu_inp_valid=2'b11, and operand/cmd/mode/cin pins hold the registered request, constant throughout.
  - In IDLE and RESP: alu_ce=0, alu_inp_valid=2'b00, operand pins keep their last values.
- RESP: rsp_valid=1. rsp_id, rsp_res and rsp_flags are stable until rsp_ready. On rsp_valid && rsp_ready, the next state is IDLE. No request is accepted in ISSUE, WAIT or RESP (req_ready=0).
- The ALU err flag is passed through unchanged. The arbiter does not interpret cmd beyond latency selection.

## Timing

- Grant in cycle G → ISSUE in G+1 → WAIT in G+2..G+1+L → rsp_valid first high in G+2+L (L = selected latency). With LAT=1 a response appears 3 cycles after grant.
- Back-to-back throughput: with rsp_ready held high, the next grant occurs in the cycle after the response handshake, giving one operation per L+3 cycles.
- req_ready depends combinationally on req_valid and state. Requesters must not make req_valid depend on req_ready.
- Reset (any state, including mid-operation):
  - Next cycle the state is IDLE, req_ready=0 during the reset cycle, rsp_valid=0, busy=0.
  - alu_ce=0, alu_inp_valid=0, alu_opa/opb/cmd/mode/cin=0.
  - rsp_id/res/flags=0, last_grant=N-1, so requester 0 wins first.
  - Any in-flight operation is dropped with no response.
- A request withdrawn before grant is ignored, with no state change. If the requester at the pointer position is idle, the next active one in cyclic order wins the same cycle.
- rsp_ready held low: the block stalls in RESP indefinitely, with ALU pins quiet and no grants.

## Test plan

- Reset then single request, requester 2: opa=8'h05, opb=8'h03, cmd=0, mode=1, LAT=1. Expect req_ready[2] in cycle G, alu_ce=1 in G+1..G+2, rsp_valid in G+3 with rsp_id=2, rsp_res=8'h08, flags=0.
- All four req_valid held high, rsp_ready=1: grants occur in order 0,1,2,3,0. Each rsp_id matches and no requester is granted twice before the others.
- Multiply (mode=1, cmd=9, MUL_LAT=2): rsp_valid appears 4 cycles after grant, and alu_opa/opb stay constant through ISSUE and both WAIT cycles.
- rsp_ready low for 5 cycles in RESP while requester 1 is valid: req_ready stays 0, rsp data is stable, and the grant to 1 happens in the cycle after the handshake.
- Reset asserted during WAIT: next cycle busy=0, rsp_valid=0, alu_ce=0, no response emitted. The next grant goes to requester 0 when 0 and 3 are both valid.
- Compare yielding g=1 (opa=8'h09 > opb=8'h02): rsp_flags equals 6'b000100 and rsp_res equals the ALU output captured at the sampling edge.
